// File: rtl/rc4_decrypt_if.sv
// Control and memory-port bundle between the RC4 decryptor and its S RAM, message ROM and result RAM.
interface rc4_decrypt_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              finish;
    logic              key_ok;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [ADDR_W-1:0] d_address;
    logic [7:0]        d_data;
    logic              d_wren;

    modport master (
        input  start, s_q, rom_q,
        output finish, key_ok, s_address, s_data, s_wren,
               rom_address, d_address, d_data, d_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  finish, key_ok, s_address, s_data, s_wren,
               rom_address, d_address, d_data, d_wren
    );
endinterface

// File: rtl/rc4_decrypt.sv
// RC4 PRGA decryptor over a pre-shuffled S array; 9 cycles per byte, aborts on the first non-lowercase/space byte.
// Memories are 1-cycle synchronous-read; no backpressure, start is a level request sampled only in IDLE and DONE.
module rc4_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = $clog2(MSG_LEN)
) (
    input logic           clk,
    input logic           rst,
    rc4_decrypt_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_D, DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [ADDR_W-1:0] r_k;
    logic              r_finish;
    logic              r_key_ok;

    logic [7:0]        w_j_sum;
    logic [7:0]        w_f_addr;
    logic [7:0]        w_plain;
    logic              w_plain_ok;
    logic              w_last;

    assign w_j_sum    = r_j + bus.s_q;
    assign w_f_addr   = r_si + r_sj;
    assign w_plain    = bus.s_q ^ bus.rom_q;
    assign w_plain_ok = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);
    assign w_last     = (r_k == ADDR_W'(MSG_LEN - 1));

    assign bus.finish = r_finish;
    assign bus.key_ok = r_key_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_i      <= 8'd0;
            r_j      <= 8'd0;
            r_si     <= 8'd0;
            r_sj     <= 8'd0;
            r_k      <= '0;
            r_finish <= 1'b0;
            r_key_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                RD_SI: r_i <= r_i + 8'd1;
                RD_SJ: begin
                    r_si <= bus.s_q;
                    r_j  <= w_j_sum;
                end
                WR_SI: r_sj <= bus.s_q;
                WR_D: begin
                    if (!w_plain_ok) begin
                        r_finish <= 1'b1;
                        r_key_ok <= 1'b0;
                    end else if (w_last) begin
                        r_finish <= 1'b1;
                        r_key_ok <= 1'b1;
                    end else begin
                        r_k <= r_k + ADDR_W'(1);
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        r_i      <= 8'd0;
                        r_j      <= 8'd0;
                        r_k      <= '0;
                        r_finish <= 1'b0;
                        r_key_ok <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Wait states keep the read address stable so q is still valid when sampled one state later.
    always_comb begin
        w_state_nxt     = r_state;
        bus.s_address   = 8'd0;
        bus.s_data      = 8'd0;
        bus.s_wren      = 1'b0;
        bus.rom_address = '0;
        bus.d_address   = '0;
        bus.d_data      = 8'd0;
        bus.d_wren      = 1'b0;
        case (r_state)
            IDLE: if (bus.start) w_state_nxt = RD_SI;
            RD_SI: begin
                bus.s_address = r_i + 8'd1;
                w_state_nxt   = WT_SI;
            end
            WT_SI: begin
                bus.s_address = r_i;
                w_state_nxt   = RD_SJ;
            end
            RD_SJ: begin
                bus.s_address = w_j_sum;
                w_state_nxt   = WT_SJ;
            end
            WT_SJ: begin
                bus.s_address = r_j;
                w_state_nxt   = WR_SI;
            end
            WR_SI: begin
                bus.s_address = r_i;
                bus.s_data    = bus.s_q;
                bus.s_wren    = 1'b1;
                w_state_nxt   = WR_SJ;
            end
            WR_SJ: begin
                bus.s_address = r_j;
                bus.s_data    = r_si;
                bus.s_wren    = 1'b1;
                w_state_nxt   = RD_F;
            end
            RD_F, WT_F: begin
                bus.s_address   = w_f_addr;
                bus.rom_address = r_k;
                w_state_nxt     = (r_state == RD_F) ? WT_F : WR_D;
            end
            WR_D: begin
                bus.d_address = r_k;
                bus.d_data    = w_plain;
                bus.d_wren    = 1'b1;
                w_state_nxt   = (!w_plain_ok || w_last) ? DONE : RD_SI;
            end
            DONE: if (!bus.start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rc4_decrypt.sv
// Directed bench for rc4_decrypt with behavioural S RAM, message ROM, result RAM and an RC4 reference model.
module tb_rc4_decrypt;
    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;

    logic clk = 1'b0;
    logic rst;

    rc4_decrypt_if #(.ADDR_W(ADDR_W)) bus ();
    rc4_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic [7:0] e_mem  [MSG_LEN];
    logic [7:0] d_mem  [MSG_LEN];
    logic [7:0] p_exp  [MSG_LEN];
    logic       s_load  = 1'b0;
    logic       mon_clr = 1'b0;

    int         s_wr_cnt;
    int         d_wr_cnt;
    logic [7:0] sw0_addr, sw0_dat, sw1_addr, sw1_dat;
    logic [ADDR_W-1:0] dw0_addr;
    logic [7:0] dw0_dat;

    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (s_load) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (bus.s_wren) begin
            s_mem[bus.s_address] <= bus.s_data;
        end
        bus.s_q   <= s_mem[bus.s_address];
        bus.rom_q <= e_mem[bus.rom_address];
        if (mon_clr) begin
            s_wr_cnt <= 0;
            d_wr_cnt <= 0;
            for (int x = 0; x < MSG_LEN; x++) d_mem[x] <= 8'hEE;
        end else begin
            if (bus.s_wren) begin
                if (s_wr_cnt == 0) begin
                    sw0_addr <= bus.s_address;
                    sw0_dat  <= bus.s_data;
                end
                if (s_wr_cnt == 1) begin
                    sw1_addr <= bus.s_address;
                    sw1_dat  <= bus.s_data;
                end
                s_wr_cnt <= s_wr_cnt + 1;
            end
            if (bus.d_wren) begin
                if (d_wr_cnt == 0) begin
                    dw0_addr <= bus.d_address;
                    dw0_dat  <= bus.d_data;
                end
                d_mem[bus.d_address] <= bus.d_data;
                d_wr_cnt <= d_wr_cnt + 1;
            end
        end
    end

    task automatic prep();
        @(negedge clk);
        s_load  = 1'b1;
        mon_clr = 1'b1;
        @(negedge clk);
        s_load  = 1'b0;
        mon_clr = 1'b0;
    endtask

    // Counts clock edges after the one that leaves IDLE until finish rises (bounded).
    task automatic run(output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.finish && cyc < 400);
    endtask

    task automatic stop_run();
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity(input logic [7:0] e0);
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        for (int k = 0; k < MSG_LEN; k++) e_mem[k] = 8'h00;
        e_mem[0] = e0;
    endtask

    task automatic model_build(input int mul, input int add, input int bad_k, input logic [7:0] bad_val);
        logic [7:0] ms [256];
        logic [7:0] i, j, si, sj, t;
        for (int x = 0; x < 256; x++) begin
            s_init[x] = 8'((x * mul + add) % 256);
            ms[x]     = s_init[x];
        end
        for (int k = 0; k < MSG_LEN; k++) begin
            p_exp[k] = (k == 7) ? 8'h20 : 8'(8'h61 + (k * 5) % 26);
            if (k == bad_k) p_exp[k] = bad_val;
        end
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < MSG_LEN; k++) begin
            i = i + 8'd1;
            si = ms[i];
            j = j + si;
            sj = ms[j];
            ms[i] = sj;
            ms[j] = si;
            t = si + sj;
            e_mem[k] = p_exp[k] ^ ms[t];
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        set_identity(8'h00);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.finish !== 1'b0 || bus.key_ok !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: finish=%b key_ok=%b expected 0 0", bus.finish, bus.key_ok);
        end
        checks++;
        if (bus.s_wren !== 1'b0 || bus.d_wren !== 1'b0) begin
            errors++;
            $display("FAIL reset_wren: s_wren=%b d_wren=%b expected 0 0", bus.s_wren, bus.d_wren);
        end
        checks++;
        if (bus.s_address !== 8'd0 || bus.s_data !== 8'd0 || bus.rom_address !== '0 ||
            bus.d_address !== '0 || bus.d_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: s_addr=%h s_data=%h rom=%h d_addr=%h d_data=%h expected all 0",
                     bus.s_address, bus.s_data, bus.rom_address, bus.d_address, bus.d_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_byte();
        int cyc;
        set_identity(8'h61);
        prep();
        run(cyc);
        checks++;
        if (dw0_addr !== 5'd0 || dw0_dat !== 8'h63) begin
            errors++;
            $display("FAIL first_byte_d: addr=%h data=%h expected 00 63", dw0_addr, dw0_dat);
        end
        checks++;
        if (sw0_addr !== 8'h01 || sw0_dat !== 8'h01 || sw1_addr !== 8'h01 || sw1_dat !== 8'h01) begin
            errors++;
            $display("FAIL first_byte_swap: %h<=%h %h<=%h expected 01<=01 01<=01",
                     sw0_addr, sw0_dat, sw1_addr, sw1_dat);
        end
        checks++;
        if (cyc !== 18 || bus.key_ok !== 1'b0 || d_wr_cnt !== 2) begin
            errors++;
            $display("FAIL first_byte_abort: cycles=%0d key_ok=%b dwrites=%0d expected 18 0 2",
                     cyc, bus.key_ok, d_wr_cnt);
        end
        stop_run();
    endtask

    task automatic test_abort_first();
        int cyc;
        set_identity(8'h00);
        prep();
        run(cyc);
        checks++;
        if (cyc !== 9 || bus.finish !== 1'b1 || bus.key_ok !== 1'b0) begin
            errors++;
            $display("FAIL abort_first: cycles=%0d finish=%b key_ok=%b expected 9 1 0", cyc, bus.finish, bus.key_ok);
        end
        checks++;
        if (d_wr_cnt !== 1 || d_mem[0] !== 8'h02) begin
            errors++;
            $display("FAIL abort_first_d: dwrites=%0d D0=%h expected 1 02", d_wr_cnt, d_mem[0]);
        end
        stop_run();
    endtask

    task automatic test_j_wrap();
        int cyc;
        set_identity(8'h70 ^ 8'h61);
        s_init[8'h01] = 8'hFF;
        s_init[8'hFF] = 8'h10;
        s_init[8'h0F] = 8'h70;
        prep();
        run(cyc);
        checks++;
        if (sw0_addr !== 8'h01 || sw0_dat !== 8'h10 || sw1_addr !== 8'hFF || sw1_dat !== 8'hFF) begin
            errors++;
            $display("FAIL j_wrap_swap: %h<=%h %h<=%h expected 01<=10 ff<=ff", sw0_addr, sw0_dat, sw1_addr, sw1_dat);
        end
        checks++;
        if (dw0_dat !== 8'h61) begin
            errors++;
            $display("FAIL j_wrap_f: D0=%h expected 61", dw0_dat);
        end
        checks++;
        if (cyc !== 18 || d_wr_cnt !== 2 || d_mem[1] !== 8'h12) begin
            errors++;
            $display("FAIL j_wrap_second: cycles=%0d dwrites=%0d D1=%h expected 18 2 12", cyc, d_wr_cnt, d_mem[1]);
        end
        stop_run();
    endtask

    task automatic test_model_run(input int mul, input int add, input int bad_k, input logic [7:0] bad_val);
        int cyc;
        int exp_cyc;
        int exp_dn;
        logic exp_ok;
        model_build(mul, add, bad_k, bad_val);
        exp_cyc = (bad_k < 0) ? 9 * MSG_LEN : 9 * (bad_k + 1);
        exp_dn  = (bad_k < 0) ? MSG_LEN : bad_k + 1;
        exp_ok  = (bad_k < 0);
        prep();
        run(cyc);
        checks++;
        if (cyc !== exp_cyc || bus.finish !== 1'b1) begin
            errors++;
            $display("FAIL run_cycles: cycles=%0d finish=%b expected %0d 1", cyc, bus.finish, exp_cyc);
        end
        checks++;
        if (bus.key_ok !== exp_ok || d_wr_cnt !== exp_dn) begin
            errors++;
            $display("FAIL run_result: key_ok=%b dwrites=%0d expected %b %0d", bus.key_ok, d_wr_cnt, exp_ok, exp_dn);
        end
        for (int k = 0; k < exp_dn; k++) begin
            checks++;
            if (d_mem[k] !== p_exp[k]) begin
                errors++;
                $display("FAIL run_dbyte[%0d]: got %h expected %h", k, d_mem[k], p_exp[k]);
            end
        end
        stop_run();
        checks++;
        if (bus.finish !== 1'b0 || bus.key_ok !== 1'b0) begin
            errors++;
            $display("FAIL run_release: finish=%b key_ok=%b expected 0 0", bus.finish, bus.key_ok);
        end
    endtask

    task automatic test_reset_mid_run();
        model_build(77, 8'hC4, -1, 8'h00);
        prep();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.s_wren !== 1'b1) begin
            errors++;
            $display("FAIL midrun_in_wr_si: s_wren=%b expected 1", bus.s_wren);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.s_wren !== 1'b0 || bus.finish !== 1'b0 || bus.s_address !== 8'd0) begin
            errors++;
            $display("FAIL midrun_async: s_wren=%b finish=%b s_addr=%h expected 0 0 00",
                     bus.s_wren, bus.finish, bus.s_address);
        end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.s_address !== 8'd0 || bus.s_wren !== 1'b0 || bus.d_wren !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: s_addr=%h s_wren=%b d_wren=%b expected 00 0 0",
                     bus.s_address, bus.s_wren, bus.d_wren);
        end
        test_model_run(77, 8'hC4, -1, 8'h00);
    endtask

    task automatic test_start_held();
        int cyc;
        set_identity(8'h00);
        prep();
        run(cyc);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (bus.finish !== 1'b1 || bus.key_ok !== 1'b0 || d_wr_cnt !== 1 || s_wr_cnt !== 2) begin
            errors++;
            $display("FAIL held_done: finish=%b key_ok=%b dwrites=%0d swrites=%0d expected 1 0 1 2",
                     bus.finish, bus.key_ok, d_wr_cnt, s_wr_cnt);
        end
        stop_run();
        checks++;
        if (bus.finish !== 1'b0) begin
            errors++;
            $display("FAIL held_release: finish=%b expected 0", bus.finish);
        end
        set_identity(8'h61);
        prep();
        run(cyc);
        checks++;
        if (dw0_addr !== 5'd0 || dw0_dat !== 8'h63 || sw0_addr !== 8'h01 || cyc !== 18) begin
            errors++;
            $display("FAIL held_restart: d_addr=%h d_data=%h s_addr=%h cycles=%0d expected 00 63 01 18",
                     dw0_addr, dw0_dat, sw0_addr, cyc);
        end
        stop_run();
    endtask

    initial begin
        test_reset();
        test_first_byte();
        test_abort_first();
        test_j_wrap();
        test_model_run(5, 8'h3B, -1, 8'h00);
        test_model_run(13, 8'h07, 3, 8'h7B);
        test_model_run(101, 8'h55, 10, 8'h60);
        test_reset_mid_run();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
